// File: rtl/scratchpad_ram_port_if.sv
// TileLink-UL A/D channel bundle between the bank fragmenter (master) and the
// scratchpad RAM port (slave).
interface scratchpad_ram_port_if;
    // A channel
    logic        auto_in_a_ready;
    logic        auto_in_a_valid;
    logic [2:0]  auto_in_a_bits_opcode;
    logic [2:0]  auto_in_a_bits_param;
    logic [1:0]  auto_in_a_bits_size;
    logic [7:0]  auto_in_a_bits_source;
    logic [27:0] auto_in_a_bits_address;
    logic [7:0]  auto_in_a_bits_mask;
    logic [63:0] auto_in_a_bits_data;
    logic        auto_in_a_bits_corrupt;
    // D channel
    logic        auto_in_d_ready;
    logic        auto_in_d_valid;
    logic [2:0]  auto_in_d_bits_opcode;
    logic [1:0]  auto_in_d_bits_size;
    logic [7:0]  auto_in_d_bits_source;
    logic [63:0] auto_in_d_bits_data;
    logic        auto_in_d_bits_denied;

    modport master (
        input  auto_in_a_ready,
        output auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_param,
               auto_in_a_bits_size, auto_in_a_bits_source, auto_in_a_bits_address,
               auto_in_a_bits_mask, auto_in_a_bits_data, auto_in_a_bits_corrupt,
        output auto_in_d_ready,
        input  auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_size,
               auto_in_d_bits_source, auto_in_d_bits_data, auto_in_d_bits_denied
    );

    modport slave (
        output auto_in_a_ready,
        input  auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_param,
               auto_in_a_bits_size, auto_in_a_bits_source, auto_in_a_bits_address,
               auto_in_a_bits_mask, auto_in_a_bits_data, auto_in_a_bits_corrupt,
        input  auto_in_d_ready,
        output auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_size,
               auto_in_d_bits_source, auto_in_d_bits_data, auto_in_d_bits_denied
    );
endinterface

// File: rtl/scratchpad_ram_port.sv
// TileLink-UL slave terminating the scratchpad bank request stream into a
// single-ported, byte-masked synchronous SRAM. One access per accepted beat,
// one D beat per request, full D backpressure.
// Optional feature: define SCRATCHPAD_RAM_DENY_EN to deny out-of-range
// addresses and unsupported opcodes; otherwise addresses alias modulo the
// RAM size and unsupported opcodes behave as Get.
module scratchpad_ram_port #(
    parameter int          DEPTH     = 8192,
    parameter logic [27:0] BASE_ADDR = 28'h000_0000
) (
    input  logic                  clock,
    input  logic                  reset,
    scratchpad_ram_port_if.slave  tl
);
    localparam int DATA_W = 64;
    localparam int IDX_W  = $clog2(DEPTH);

    typedef enum logic {IDLE, RESP} state_t;

    state_t              state;
    logic [2:0]          d_opcode_q;
    logic [1:0]          d_size_q;
    logic [7:0]          d_source_q;
    logic                d_denied_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                d_valid_q;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                a_ready;
    logic                accept;
    logic                is_put;
    logic                is_get;
    logic                deny;
    logic                do_write;
    logic                do_read;
    logic [IDX_W-1:0]    idx;

    assign d_valid_q = (state == RESP);
    // d_ready -> a_ready is the only combinational path through the block.
    assign a_ready   = !reset && (!d_valid_q || tl.auto_in_d_ready);
    assign accept    = tl.auto_in_a_valid && a_ready;
    assign idx       = tl.auto_in_a_bits_address[IDX_W+2:3];
    assign is_put    = (tl.auto_in_a_bits_opcode == 3'd0) ||
                       (tl.auto_in_a_bits_opcode == 3'd1);

`ifdef SCRATCHPAD_RAM_DENY_EN
    localparam logic [28:0] LIMIT = 29'(BASE_ADDR) + 29'(DEPTH * 8);

    logic in_range;

    assign in_range = (tl.auto_in_a_bits_address >= BASE_ADDR) &&
                      ({1'b0, tl.auto_in_a_bits_address} < LIMIT);
    assign is_get   = (tl.auto_in_a_bits_opcode == 3'd4);
    assign deny     = !in_range || !(is_get || is_put);
`else
    // Unsupported opcodes fall through to a read; no access is ever refused.
    assign is_get   = !is_put;
    assign deny     = 1'b0;
`endif

    // param is ignored; address bits outside the word index are consumed only
    // by the range check (when present) or not at all.
    logic unused_ok;
    assign unused_ok = ^{tl.auto_in_a_bits_param, tl.auto_in_a_bits_address};

    assign do_write = accept && is_put && !deny && !tl.auto_in_a_bits_corrupt;
    assign do_read  = accept && is_get && !deny;

    // SRAM array: byte-lane masked write and registered read, never both on one edge.
    always_ff @(posedge clock) begin
        if (do_write) begin
            for (int i = 0; i < 8; i++) begin
                if (tl.auto_in_a_bits_mask[i]) begin
                    mem[idx][8*i +: 8] <= tl.auto_in_a_bits_data[8*i +: 8];
                end
            end
        end
        if (do_read) begin
            rd_data_q <= mem[idx];
        end
    end

    // Response FSM: IDLE holds no response, RESP holds one until D fires.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            d_opcode_q <= 3'd0;
            d_size_q   <= 2'd0;
            d_source_q <= 8'd0;
            d_denied_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (!accept && tl.auto_in_d_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (accept) begin
                d_opcode_q <= is_get ? 3'd1 : 3'd0;
                d_size_q   <= tl.auto_in_a_bits_size;
                d_source_q <= tl.auto_in_a_bits_source;
                d_denied_q <= deny;
            end
        end
    end

    assign tl.auto_in_a_ready       = a_ready;
    assign tl.auto_in_d_valid       = d_valid_q;
    assign tl.auto_in_d_bits_opcode = d_opcode_q;
    assign tl.auto_in_d_bits_size   = d_size_q;
    assign tl.auto_in_d_bits_source = d_source_q;
    assign tl.auto_in_d_bits_denied = d_denied_q;
    // Denied reads return zero rather than whatever the read register last held.
    assign tl.auto_in_d_bits_data   = (d_opcode_q == 3'd1 && !d_denied_q) ?
                                      rd_data_q : '0;
endmodule

// File: doc/scratchpad_ram_port.md
# scratchpad_ram_port

TileLink-UL slave that terminates the scratchpad bank's fragmented request stream into a single-ported, byte-masked synchronous SRAM. It sits directly downstream of the bank's TL fragmenter and upstream of nothing. It accepts at most one beat per cycle, performs one SRAM access per accepted beat, and returns one D-channel beat per request with full backpressure support.

## Interface
- DEPTH, 8192: number of 64-bit words; must be a power of two. Default gives 64 KiB.
- BASE_ADDR, 28'h000_0000: byte address of word 0; aligned to DEPTH*8.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- auto_in_a_ready  out  1  A-channel ready.
- auto_in_a_valid  in  1  A-channel valid.
- auto_in_a_bits_opcode  in  3  0 PutFull, 1 PutPartial, 4 Get.
- auto_in_a_bits_param  in  3  ignored.
- auto_in_a_bits_size  in  2  log2 bytes, 0..3.
- auto_in_a_bits_source  in  8  echoed on D.
- auto_in_a_bits_address  in  28  byte address.
- auto_in_a_bits_mask  in  8  byte lanes.
- auto_in_a_bits_data  in  64  write data.
- auto_in_a_bits_corrupt  in  1  when set on a Put, the write is suppressed.
- auto_in_d_ready  in  1  D-channel ready.
- auto_in_d_valid  out  1  D-channel valid.
- auto_in_d_bits_opcode  out  3  0 AccessAck, 1 AccessAckData.
- auto_in_d_bits_size  out  2  echo of the request size.
- auto_in_d_bits_source  out  8  echo of the request source.
- auto_in_d_bits_data  out  64  read data; 0 for AccessAck.
- auto_in_d_bits_denied  out  1  error response (see Configuration).

## Operation
- Word index is address[log2(DEPTH)+2:3]. Address bits [2:0] are used only through the mask.
- Handshake:
  - auto_in_a_ready = !reset && (!d_valid_q || auto_in_d_ready).
  - A beat is accepted when auto_in_a_valid and auto_in_a_ready are both high.
- Accept of a Get:
  - SRAM read enable is asserted.
  - d_opcode_q=1, and size and source are latched.
- Accept of a Put (opcode 0 or 1):
  - SRAM write occurs on the same edge, for each byte lane i with mask[i]=1 and corrupt=0.
  - d_opcode_q=0.
- d_valid_q is set on accept and cleared on a D fire (valid && ready) with no simultaneous accept. A fire together with an accept keeps it at 1 and loads the new response.
- auto_in_d_bits_data:
  - Driven by the SRAM read port when d_opcode_q=1; otherwise 0.
  - The SRAM output register is held stable while D stalls. No new access can occur, because a_ready is low.
- Opcodes 2, 3, 5, 6, 7 are handled per Configuration.
- State: IDLE (d_valid_q=0) and RESP (d_valid_q=1).
  - IDLE→RESP on accept.
  - RESP→IDLE on a fire without an accept.
  - RESP→RESP on a fire with an accept.
- Reset:
  - d_valid_q=0, d_opcode_q=0, d_size_q=0, d_source_q=0, d_denied_q=0.
  - auto_in_a_ready=0 while reset is high.
  - A response pending at reset is dropped.
  - SRAM contents are not cleared; reads before any write return undefined data.

## Timing
- Latency: a beat accepted at edge N has its response valid from edge N+1. auto_in_d_bits_* are stable until the fire.
- Throughput: one beat per cycle while auto_in_d_ready=1.
- Read-after-write to the same word on consecutive accepts returns the new data, because the write edge precedes the read edge.
- No combinational path from auto_in_a_* to auto_in_d_*. The only combinational path is auto_in_d_ready → auto_in_a_ready.

## Configuration
- SCRATCHPAD_RAM_DENY_EN defined:
  - An address outside [BASE_ADDR, BASE_ADDR+DEPTH*8), or an unsupported opcode, produces a response with denied=1 and no SRAM write.
  - The response opcode is AccessAckData with data 0 for a Get, and AccessAck otherwise. Unsupported opcodes respond with AccessAck.
- SCRATCHPAD_RAM_DENY_EN undefined:
  - auto_in_d_bits_denied is tied to 0.
  - Address is taken modulo DEPTH*8, so it aliases.
  - Unsupported opcodes are treated as Get.

## Test plan
- Reset, then idle → a_ready=1 and d_valid=0 on the first cycle after reset deasserts. All D bits are 0.
- PutFull of 0x1122334455667788 to word 5, mask 0xFF, source 0x3A → D at N+1: opcode 0, source 0x3A, data 0. A Get of word 5 then returns 0x1122334455667788.
- PutPartial of 0xAAAA… with mask 0x0F to word 5, then Get → 0x11223344AAAAAAAA.
- Back-to-back Put then Get of the same word with d_ready=1 → two consecutive responses, and the Get returns the new data.
- Get accepted, then d_ready held 0 for 5 cycles:
  - a_ready is 0 and d_bits_data is constant throughout.
  - Fire when d_ready rises; the next queued Get is accepted in the same cycle.
- DENY_EN: Get at BASE_ADDR+DEPTH*8 → denied=1, data 0. Without DENY_EN, the same Get returns the contents of word 0.
- Reset asserted while d_valid=1 → d_valid=0 on the next edge, and no response is produced afterwards.
